fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
- Upstream producer for the team's 6-bit test FIFO. Generates an incrementing data stream on the FIFO write port.
- Writes in bursts and respects `full`. After each burst, waits for the FIFO to drain (`empty`) before starting the next one.
- Enforces a settle delay after enable, because the FIFO is not write-ready for several cycles after reset.
- Sits directly in front of the FIFO's `din`/`wr_en`/`full`/`empty` interface.

Parameters:
- DATA_W, 6, width of the generated data word (matches FIFO `din`).
- BURST_LEN, 8, words per burst; 0 = write until `full`.
- START_DLY, 10, idle cycles in SETTLE before the first write of each enable session (1..255).
- CNT_W, 16, width of the total-words-written counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  level enable for generation.
- full  input  1  FIFO full flag.
- empty  input  1  FIFO empty flag.
- wr_en  output  1  FIFO write strobe; a write is accepted on any cycle with wr_en=1.
- din  output  DATA_W  FIFO write data.
- busy  output  1  high whenever state != IDLE.
- burst_done  output  1  one-cycle pulse on the cycle after the final write of a burst.
- wr_total  output  CNT_W  count of accepted writes since reset.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, din=0, wr_en=0, busy=0, burst_done=0, wr_total=0, burst counter=0, settle counter=0. Reset takes priority over every other event, including mid-burst.
- States: IDLE, SETTLE, WRITE, DRAIN_WAIT.
- IDLE:
  - en=1 → SETTLE; settle counter loaded to 0.
- SETTLE:
  - Counts START_DLY cycles.
  - When the count reaches START_DLY-1 and en=1 → WRITE.
  - en=0 at any point → IDLE.
- WRITE:
  - wr_en is combinational: (state==WRITE) && !full && (BURST_LEN==0 || burst_cnt<BURST_LEN).
  - On each accepted write: din <= din+1 (modulo 2^DATA_W, so 63 → 0), burst_cnt++, wr_total++ (wraps at 2^CNT_W).
  - full=1: wr_en=0 in the same cycle; din, burst_cnt and state hold. Writing resumes the cycle full drops.
  - Burst end when BURST_LEN>0: the cycle burst_cnt reaches BURST_LEN → DRAIN_WAIT; burst_done=1 for exactly that one cycle; burst_cnt cleared.
  - Burst end when BURST_LEN==0: the first cycle in WRITE with full=1, after at least one write in this burst → DRAIN_WAIT, with burst_done pulsed.
  - en=0 in WRITE: the write on the current cycle (if any) completes; next state IDLE; no burst_done pulse; burst_cnt cleared.
- DRAIN_WAIT:
  - wr_en=0.
  - empty=1 and en=1 → WRITE directly; no re-settle.
  - en=0 → IDLE.
- Data continuity: din is never cleared except by rst. The sequence continues across bursts and across en toggles.
- Latency: with en rising at edge N, the first wr_en=1 occurs in cycle N+1+START_DLY (assuming full=0).
- Invariants:
  - wr_en is never 1 while full=1 or while state != WRITE.
  - burst_done and wr_en are never both 1 when BURST_LEN>0.

Test Plan:
- Settle and first burst: rst high 20 cycles then low; en=1, full=0, BURST_LEN=8.
  - Required: wr_en=0 for exactly 10 cycles, then 8 consecutive writes with din=0..7.
  - Then burst_done=1 for one cycle, wr_total=8, state DRAIN_WAIT, wr_en=0.
- Backpressure: during a burst, assert full for 3 cycles after the write of din=3.
  - Required: wr_en=0 in those exact cycles, din holds 4.
  - Writes 4..7 resume the cycle full drops; still 8 writes total.
- Drain and next burst: after the first burst, hold empty=0 for 20 cycles, then set empty=1.
  - Required: no writes while empty=0; next burst starts without settle delay, din=8..15, wr_total=16.
- Wrap and until-full mode: BURST_LEN=0, full asserted after 70 writes.
  - Required: din wraps 63 → 0; burst_done pulses once; wr_total=70; din=6 held.
- Reset mid-write: assert rst on the cycle wr_en=1 with din=5.
  - Required: next edge gives wr_en=0, din=0, wr_total=0, busy=0, state IDLE.
- Enable drop: deassert en during SETTLE and separately during WRITE.
  - Required: busy=0 the next cycle, no burst_done pulse.
  - On re-enable: full START_DLY settle repeats, din continues from its retained value.

Source files
------------

// File: rtl/fifo_wr_if.sv
// Write-side port bundle between a data producer and the test FIFO.
// valid/ready: a word on din is transferred on every rising edge where wr_en=1; full=1 forbids wr_en.
interface fifo_wr_if #(
  parameter int DATA_W = 6
) ();
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              full;
  logic              empty;

  modport master (output din, output wr_en, input full, input empty);
  modport slave  (input din, input wr_en, output full, output empty);
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Burst producer for the test FIFO: settle after enable, write an incrementing
// stream in bursts honouring full, then wait for the FIFO to drain before the next burst.
module fifo_wr_ctrl #(
  parameter int DATA_W    = 6,
  parameter int BURST_LEN = 8,
  parameter int START_DLY = 10,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  fifo_wr_if.master        fifo,
  output logic             busy,
  output logic             burst_done,
  output logic [CNT_W-1:0] wr_total,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETTLE     = 2'd1,
    WRITE      = 2'd2,
    DRAIN_WAIT = 2'd3
  } state_t;

  // In until-full mode the burst counter only has to remember "at least one write".
  localparam int             BCW         = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN + 1);
  localparam logic [BCW-1:0] BL_VAL      = BCW'(BURST_LEN);
  localparam logic [BCW-1:0] BL_LAST     = BCW'(BURST_LEN - 1);
  localparam logic [7:0]     SETTLE_LAST = 8'(START_DLY - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_settle_cnt;
  logic [7:0]        w_settle_nxt;
  logic [BCW-1:0]    r_burst_cnt;
  logic [BCW-1:0]    w_burst_nxt;
  logic              r_burst_done;
  logic              w_done_nxt;
  logic [DATA_W-1:0] r_din;
  logic [CNT_W-1:0]  r_wr_total;
  logic              w_room;
  logic              w_wr_en;

  assign w_room  = (BURST_LEN == 0) || (r_burst_cnt < BL_VAL);
  assign w_wr_en = (r_state == WRITE) && !fifo.full && w_room;

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_burst_nxt  = r_burst_cnt;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt  = SETTLE;
          w_settle_nxt = 8'd0;
        end
      end
      SETTLE: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = WRITE;
        end else begin
          w_settle_nxt = r_settle_cnt + 8'd1;
        end
      end
      WRITE: begin
        if (w_wr_en) begin
          w_burst_nxt = (BURST_LEN == 0) ? BCW'(1) : r_burst_cnt + BCW'(1);
        end
        // Dropping enable lets the in-flight write land but abandons the burst silently.
        if (!en) begin
          w_state_nxt = IDLE;
          w_burst_nxt = '0;
        end else if ((BURST_LEN != 0) && w_wr_en && (r_burst_cnt == BL_LAST)) begin
          w_state_nxt = DRAIN_WAIT;
          w_done_nxt  = 1'b1;
          w_burst_nxt = '0;
        end else if ((BURST_LEN == 0) && fifo.full && (r_burst_cnt != '0)) begin
          w_state_nxt = DRAIN_WAIT;
          w_done_nxt  = 1'b1;
          w_burst_nxt = '0;
        end
      end
      DRAIN_WAIT: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (fifo.empty) begin
          w_state_nxt = WRITE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_settle_cnt <= 8'd0;
      r_burst_cnt  <= '0;
      r_burst_done <= 1'b0;
      r_din        <= '0;
      r_wr_total   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_burst_done <= w_done_nxt;
      if (w_wr_en) begin
        r_din      <= r_din + DATA_W'(1);
        r_wr_total <= r_wr_total + CNT_W'(1);
      end
    end
  end

  assign fifo.din    = r_din;
  assign fifo.wr_en  = w_wr_en;
  assign busy        = (r_state != IDLE);
  assign burst_done  = r_burst_done;
  assign wr_total    = r_wr_total;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: instance A runs 8-word bursts, instance B runs until-full mode.
module tb_fifo_wr_ctrl;
  localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_WRITE = 2'd2, S_DRAIN = 2'd3;

  logic        clk;
  logic        rst_a, en_a, busy_a, done_a;
  logic [15:0] tot_a;
  logic [1:0]  st_a;
  logic        rst_b, en_b, busy_b, done_b;
  logic [15:0] tot_b;
  logic [1:0]  st_b;
  int          n_cmp;
  int          n_fail;

  fifo_wr_if #(.DATA_W(6)) if_a ();
  fifo_wr_if #(.DATA_W(6)) if_b ();

  fifo_wr_ctrl #(.DATA_W(6), .BURST_LEN(8), .START_DLY(10), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .fifo(if_a.master),
    .busy(busy_a), .burst_done(done_a), .wr_total(tot_a), .state_dbg(st_a)
  );

  fifo_wr_ctrl #(.DATA_W(6), .BURST_LEN(0), .START_DLY(10), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .fifo(if_b.master),
    .busy(busy_b), .burst_done(done_b), .wr_total(tot_b), .state_dbg(st_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_settle_a(input logic [5:0] exp_din);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      #1;
      n_cmp++;
      if (st_a !== S_SETTLE || if_a.wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL settle[%0d]: state=%0d wr_en=%b, required state=%0d wr_en=0", i, st_a, if_a.wr_en, S_SETTLE);
      end
    end
    next_cycle();
    #1;
    n_cmp++;
    if (if_a.wr_en !== 1'b1 || if_a.din !== exp_din) begin
      n_fail++;
      $display("FAIL first_write: wr_en=%b din=%0d, required wr_en=1 din=%0d", if_a.wr_en, if_a.din, exp_din);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    if_a.full = 1'b0; if_a.empty = 1'b0; if_b.full = 1'b0; if_b.empty = 1'b0;
    for (int i = 0; i < 20; i++) next_cycle();
    #1;
    n_cmp++;
    if ({busy_a, done_a, if_a.wr_en, st_a} !== 5'b0 || if_a.din !== 6'd0 || tot_a !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_a: busy=%b done=%b wr_en=%b st=%0d din=%0d total=%0d, required all 0",
               busy_a, done_a, if_a.wr_en, st_a, if_a.din, tot_a);
    end
    n_cmp++;
    if ({busy_b, done_b, if_b.wr_en, st_b} !== 5'b0 || if_b.din !== 6'd0 || tot_b !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_b: busy=%b done=%b wr_en=%b st=%0d din=%0d total=%0d, required all 0",
               busy_b, done_b, if_b.wr_en, st_b, if_b.din, tot_b);
    end
  endtask

  // First burst with full held for 3 cycles right after the write of din=3.
  task automatic test_first_burst_backpressure();
    logic       exp_wr;
    logic [5:0] exp_din;
    rst_a = 1'b0;
    en_a  = 1'b1;
    check_settle_a(6'd0);
    for (int k = 1; k < 11; k++) begin
      next_cycle();
      if_a.full = (k >= 4 && k <= 6);
      exp_wr  = !(k >= 4 && k <= 6);
      exp_din = (k < 4) ? 6'(k) : (k < 7) ? 6'd4 : 6'(k - 3);
      #1;
      n_cmp++;
      if (if_a.wr_en !== exp_wr || if_a.din !== exp_din || done_a !== 1'b0) begin
        n_fail++;
        $display("FAIL burst1[%0d]: wr_en=%b din=%0d done=%b, required wr_en=%b din=%0d done=0",
                 k, if_a.wr_en, if_a.din, done_a, exp_wr, exp_din);
      end
    end
    next_cycle();
    if_a.full = 1'b0;
    #1;
    n_cmp++;
    if (done_a !== 1'b1 || tot_a !== 16'd8 || st_a !== S_DRAIN || if_a.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL burst1_end: done=%b total=%0d st=%0d wr_en=%b, required done=1 total=8 st=3 wr_en=0",
               done_a, tot_a, st_a, if_a.wr_en);
    end
    next_cycle();
    #1;
    n_cmp++;
    if (done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL burst1_done_width: done=%b, required 0", done_a);
    end
  endtask

  task automatic test_drain_next_burst();
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      #1;
      n_cmp++;
      if (if_a.wr_en !== 1'b0 || st_a !== S_DRAIN) begin
        n_fail++;
        $display("FAIL drain_hold[%0d]: wr_en=%b st=%0d, required wr_en=0 st=3", i, if_a.wr_en, st_a);
      end
    end
    next_cycle();
    if_a.empty = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if_a.empty = 1'b0;
      #1;
      n_cmp++;
      if (if_a.wr_en !== 1'b1 || if_a.din !== 6'(8 + k)) begin
        n_fail++;
        $display("FAIL burst2[%0d]: wr_en=%b din=%0d, required wr_en=1 din=%0d", k, if_a.wr_en, if_a.din, 8 + k);
      end
    end
    next_cycle();
    #1;
    n_cmp++;
    if (done_a !== 1'b1 || tot_a !== 16'd16 || st_a !== S_DRAIN) begin
      n_fail++;
      $display("FAIL burst2_end: done=%b total=%0d st=%0d, required done=1 total=16 st=3", done_a, tot_a, st_a);
    end
  endtask

  task automatic test_enable_drop();
    next_cycle();
    en_a = 1'b0;
    next_cycle();
    #1;
    n_cmp++;
    if (busy_a !== 1'b0 || st_a !== S_IDLE) begin
      n_fail++;
      $display("FAIL drop_drain: busy=%b st=%0d, required busy=0 st=0", busy_a, st_a);
    end
    en_a = 1'b1;
    for (int i = 0; i < 3; i++) next_cycle();
    #1;
    n_cmp++;
    if (st_a !== S_SETTLE) begin
      n_fail++;
      $display("FAIL drop_pre_settle: st=%0d, required st=1", st_a);
    end
    en_a = 1'b0;
    next_cycle();
    #1;
    n_cmp++;
    if (busy_a !== 1'b0 || st_a !== S_IDLE || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_settle: busy=%b st=%0d done=%b, required busy=0 st=0 done=0", busy_a, st_a, done_a);
    end
    en_a = 1'b1;
    check_settle_a(6'd16);
    next_cycle();
    #1;
    n_cmp++;
    if (if_a.wr_en !== 1'b1 || if_a.din !== 6'd17) begin
      n_fail++;
      $display("FAIL resume_write: wr_en=%b din=%0d, required wr_en=1 din=17", if_a.wr_en, if_a.din);
    end
    next_cycle();
    en_a = 1'b0;
    #1;
    n_cmp++;
    if (if_a.wr_en !== 1'b1 || if_a.din !== 6'd18) begin
      n_fail++;
      $display("FAIL last_write: wr_en=%b din=%0d, required wr_en=1 din=18", if_a.wr_en, if_a.din);
    end
    next_cycle();
    #1;
    n_cmp++;
    if (busy_a !== 1'b0 || if_a.din !== 6'd19 || tot_a !== 16'd19 || done_a !== 1'b0 || if_a.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_write: busy=%b din=%0d total=%0d done=%b wr_en=%b, required busy=0 din=19 total=19 done=0 wr_en=0",
               busy_a, if_a.din, tot_a, done_a, if_a.wr_en);
    end
    en_a = 1'b1;
    check_settle_a(6'd19);
  endtask

  task automatic test_reset_mid_write();
    rst_a = 1'b1;
    en_a  = 1'b0;
    next_cycle();
    next_cycle();
    rst_a = 1'b0;
    en_a  = 1'b1;
    check_settle_a(6'd0);
    for (int k = 1; k < 6; k++) begin
      next_cycle();
      if (k == 5) rst_a = 1'b1;
      #1;
      n_cmp++;
      if (if_a.wr_en !== 1'b1 || if_a.din !== 6'(k)) begin
        n_fail++;
        $display("FAIL pre_reset[%0d]: wr_en=%b din=%0d, required wr_en=1 din=%0d", k, if_a.wr_en, if_a.din, k);
      end
    end
    next_cycle();
    #1;
    n_cmp++;
    if (if_a.wr_en !== 1'b0 || if_a.din !== 6'd0 || tot_a !== 16'd0 || busy_a !== 1'b0 || st_a !== S_IDLE) begin
      n_fail++;
      $display("FAIL mid_reset: wr_en=%b din=%0d total=%0d busy=%b st=%0d, required all 0",
               if_a.wr_en, if_a.din, tot_a, busy_a, st_a);
    end
    rst_a = 1'b0;
    en_a  = 1'b0;
  endtask

  task automatic test_wrap_until_full();
    int done_seen;
    rst_b = 1'b0;
    en_b  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      #1;
      n_cmp++;
      if (if_b.wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL b_settle[%0d]: wr_en=%b, required 0", i, if_b.wr_en);
      end
    end
    for (int k = 0; k < 70; k++) begin
      next_cycle();
      #1;
      n_cmp++;
      if (if_b.wr_en !== 1'b1 || if_b.din !== 6'(k % 64) || done_b !== 1'b0) begin
        n_fail++;
        $display("FAIL b_write[%0d]: wr_en=%b din=%0d done=%b, required wr_en=1 din=%0d done=0",
                 k, if_b.wr_en, if_b.din, done_b, k % 64);
      end
    end
    next_cycle();
    if_b.full = 1'b1;
    #1;
    n_cmp++;
    if (if_b.wr_en !== 1'b0 || if_b.din !== 6'd6 || st_b !== S_WRITE) begin
      n_fail++;
      $display("FAIL b_full: wr_en=%b din=%0d st=%0d, required wr_en=0 din=6 st=2", if_b.wr_en, if_b.din, st_b);
    end
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      if (done_b === 1'b1) done_seen++;
    end
    n_cmp++;
    if (done_seen != 1 || tot_b !== 16'd70 || if_b.din !== 6'd6 || st_b !== S_DRAIN) begin
      n_fail++;
      $display("FAIL b_end: done_pulses=%0d total=%0d din=%0d st=%0d, required 1 70 6 3",
               done_seen, tot_b, if_b.din, st_b);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_first_burst_backpressure();
    test_drain_next_burst();
    test_enable_drop();
    test_reset_mid_write();
    test_wrap_until_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
